sram_bus_responder: RTL and testbench

//  Synthesizable responder for the async-SRAM bus that the sram controller drives (18b addr, 16b data,
//  nCE/nOE/nWE/nLB/nUB). Answers that bus from on-chip byte-enable RAM, so the controller can be

---
 rtl/sram_pkg.sv | 50 +++++
 rtl/sram_bus_responder_if.sv | 31 +++
 rtl/sram_resp_mem.sv | 26 ++
 rtl/sram_bus_responder.sv | 108 ++++++++++
 tb/tb_sram_bus_responder.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_pkg.sv
// Shared async-SRAM bus definitions: widths, cycle classification and the
// registered bus sample used by the responder (and the controller side).
package sram_pkg;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    CYC_IDLE,
    CYC_READ,
    CYC_WRITE,
    CYC_CONTEND
  } sram_cyc_e;

  typedef struct packed {
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
    logic                   nCE;
    logic                   nOE;
    logic                   nWE;
    logic                   nLB;
    logic                   nUB;
  } bus_sample_t;

  // All strobes released: what the sample stage holds out of reset.
  localparam bus_sample_t BUS_IDLE = '{
    addr:  '0,
    wdata: '0,
    nCE:   1'b1,
    nOE:   1'b1,
    nWE:   1'b1,
    nLB:   1'b1,
    nUB:   1'b1
  };

  function automatic sram_cyc_e classify(input logic n_ce, input logic n_oe, input logic n_we);
    sram_cyc_e cyc;
    cyc = CYC_IDLE;
    if (!n_ce) begin
      unique case ({n_oe, n_we})
        2'b01:   cyc = CYC_READ;
        2'b10:   cyc = CYC_WRITE;
        2'b00:   cyc = CYC_CONTEND;
        default: cyc = CYC_IDLE;
      endcase
    end
    return cyc;
  endfunction

endpackage

// File: rtl/sram_bus_responder_if.sv
// Async-SRAM address/strobe bundle; the controller is the master, the
// on-chip responder is the slave. The data bus stays a separate inout.
interface sram_bus_responder_if;
  import sram_pkg::*;

  logic [SRAM_ADDR_W-1:0] i_addr;
  logic                   i_nCE;
  logic                   i_nOE;
  logic                   i_nWE;
  logic                   i_nLB;
  logic                   i_nUB;

  modport master (
    output i_addr,
    output i_nCE,
    output i_nOE,
    output i_nWE,
    output i_nLB,
    output i_nUB
  );

  modport slave (
    input i_addr,
    input i_nCE,
    input i_nOE,
    input i_nWE,
    input i_nLB,
    input i_nUB
  );

endinterface

// File: rtl/sram_resp_mem.sv
// Single-port two-lane byte-enable RAM with registered read; no reset so it
// maps onto block RAM.
module sram_resp_mem #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we_lo,
  input  logic              we_hi,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [7:0] ram_lo [DEPTH];
  logic [7:0] ram_hi [DEPTH];

  always_ff @(posedge clk) begin
    if (we_lo) ram_lo[addr] <= wdata[7:0];
    if (we_hi) ram_hi[addr] <= wdata[15:8];
    if (re)    rdata        <= {ram_hi[addr], ram_lo[addr]};
  end

endmodule

// File: rtl/sram_bus_responder.sv
// Answers the async-SRAM bus from on-chip RAM: samples strobes on each clock,
// commits writes / returns reads one edge later, flags misuse, counts accesses.
module sram_bus_responder
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  inout  logic [SRAM_DATA_W-1:0] io_data,
  sram_bus_responder_if.slave    bus,
  output logic                   o_err_contention,
  output logic                   o_err_range,
  output logic [CNT_W-1:0]       o_rd_count,
  output logic [CNT_W-1:0]       o_wr_count
);

  bus_sample_t            s_d;
  bus_sample_t            s_q;
  sram_cyc_e              cyc;
  logic                   is_access;
  logic                   range_hit;
  logic                   mem_we_lo;
  logic                   mem_we_hi;
  logic                   mem_re;
  logic [SRAM_DATA_W-1:0] rdata_q;
  logic                   rd_valid;
  logic                   err_contention;
  logic                   err_range;
  logic [CNT_W-1:0]       rd_cnt;
  logic [CNT_W-1:0]       wr_cnt;
  logic                   rd_live;
  logic                   en_lo;
  logic                   en_hi;

  // Stage S: capture the whole bus, including write data, every edge.
  always_comb begin
    s_d       = BUS_IDLE;
    s_d.addr  = bus.i_addr;
    s_d.wdata = io_data;
    s_d.nCE   = bus.i_nCE;
    s_d.nOE   = bus.i_nOE;
    s_d.nWE   = bus.i_nWE;
    s_d.nLB   = bus.i_nLB;
    s_d.nUB   = bus.i_nUB;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) s_q <= BUS_IDLE;
    else            s_q <= s_d;
  end

  // Shift rather than slice so ADDR_W == SRAM_ADDR_W needs no special case.
  always_comb begin
    cyc       = classify(s_q.nCE, s_q.nOE, s_q.nWE);
    is_access = (cyc == CYC_READ) || (cyc == CYC_WRITE);
    range_hit = (s_q.addr >> ADDR_W) != '0;
    mem_we_lo = (cyc == CYC_WRITE) && !s_q.nLB;
    mem_we_hi = (cyc == CYC_WRITE) && !s_q.nUB;
    mem_re    = (cyc == CYC_READ);
  end

  sram_resp_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (i_clk),
    .we_lo (mem_we_lo),
    .we_hi (mem_we_hi),
    .re    (mem_re),
    .addr  (s_q.addr[ADDR_W-1:0]),
    .wdata (s_q.wdata),
    .rdata (rdata_q)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_valid       <= 1'b0;
      err_contention <= 1'b0;
      err_range      <= 1'b0;
      rd_cnt         <= '0;
      wr_cnt         <= '0;
    end else begin
      rd_valid <= (cyc == CYC_READ);
      if (cyc == CYC_CONTEND)     err_contention <= 1'b1;
      if (is_access && range_hit) err_range      <= 1'b1;
      if ((cyc == CYC_READ) && (rd_cnt != '1))  rd_cnt <= rd_cnt + CNT_W'(1);
      if ((cyc == CYC_WRITE) && (wr_cnt != '1)) wr_cnt <= wr_cnt + CNT_W'(1);
    end
  end

  // Enables follow the live strobes so the bus is released the same cycle
  // the master turns it around, independent of the registered read.
  always_comb begin
    rd_live = rd_valid && !bus.i_nCE && !bus.i_nOE && bus.i_nWE;
    en_lo   = rd_live && !bus.i_nLB;
    en_hi   = rd_live && !bus.i_nUB;
  end

  assign io_data[7:0]  = en_lo ? rdata_q[7:0]  : 'z;
  assign io_data[15:8] = en_hi ? rdata_q[15:8] : 'z;

  assign o_err_contention = err_contention;
  assign o_err_range      = err_range;
  assign o_rd_count       = rd_cnt;
  assign o_wr_count       = wr_cnt;

endmodule

// File: tb/tb_sram_bus_responder.sv
// Bench for sram_bus_responder: directed vector table, hand-written reset and
// saturation sequences, then random traffic against a word/byte-level model.
module tb_sram_bus_responder;
  import sram_pkg::*;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
  localparam int unsigned DEPTH   = 1 << ADDR_W;

  typedef enum int unsigned {OP_IDLE, OP_RD, OP_WR, OP_CT} op_e;

  typedef struct {
    op_e          op;
    logic [17:0]  addr;
    logic         nlb;
    logic         nub;
    logic [15:0]  wd;
    logic [15:0]  exp_io;
    int unsigned  exp_rd;
    int unsigned  exp_wr;
    logic         exp_ec;
    logic         exp_er;
  } vec_t;

  logic             i_clk;
  logic             i_reset_n;
  tri1 [15:0]       io_data;
  logic             tb_drv;
  logic [15:0]      tb_wd;
  logic             o_err_contention;
  logic             o_err_range;
  logic [CNT_W-1:0] o_rd_count;
  logic [CNT_W-1:0] o_wr_count;

  int unsigned nvec;
  int unsigned nmis;

  sram_bus_responder_if bus ();

  assign io_data = tb_drv ? tb_wd : 'z;

  sram_bus_responder #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .io_data          (io_data),
    .bus              (bus),
    .o_err_contention (o_err_contention),
    .o_err_range      (o_err_range),
    .o_rd_count       (o_rd_count),
    .o_wr_count       (o_wr_count)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input op_e op, input logic [17:0] a, input logic nlb, input logic nub,
                       input logic [15:0] wd);
    bus.i_addr = a;
    bus.i_nLB  = nlb;
    bus.i_nUB  = nub;
    tb_wd      = wd;
    tb_drv     = (op == OP_WR);
    case (op)
      OP_RD:   begin bus.i_nCE = 1'b0; bus.i_nOE = 1'b0; bus.i_nWE = 1'b1; end
      OP_WR:   begin bus.i_nCE = 1'b0; bus.i_nOE = 1'b1; bus.i_nWE = 1'b0; end
      OP_CT:   begin bus.i_nCE = 1'b0; bus.i_nOE = 1'b0; bus.i_nWE = 1'b0; end
      default: begin bus.i_nCE = 1'b1; bus.i_nOE = 1'b1; bus.i_nWE = 1'b1; end
    endcase
  endtask

  task automatic step(input op_e op, input logic [17:0] a, input logic nlb, input logic nub,
                      input logic [15:0] wd);
    drive(op, a, nlb, nub, wd);
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_state(input string nm, input logic [15:0] exp_io, input int unsigned rd,
                             input int unsigned wr, input logic ec, input logic er);
    check({nm, "_io"}, io_data, exp_io);
    check({nm, "_rd"}, o_rd_count, rd);
    check({nm, "_wr"}, o_wr_count, wr);
    check({nm, "_ec"}, o_err_contention, ec);
    check({nm, "_er"}, o_err_range, er);
  endtask

  function automatic vec_t mk(input op_e op, input logic [17:0] a, input logic nlb, input logic nub,
                              input logic [15:0] wd, input logic [15:0] eio, input int unsigned rd,
                              input int unsigned wr, input logic ec, input logic er);
    vec_t v;
    v.op = op; v.addr = a; v.nlb = nlb; v.nub = nub; v.wd = wd;
    v.exp_io = eio; v.exp_rd = rd; v.exp_wr = wr; v.exp_ec = ec; v.exp_er = er;
    return v;
  endfunction

  function automatic int unsigned sat_inc(input int unsigned c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 1;
  endfunction

  // Reference model state for the random phase.
  logic [15:0] ref_mem [DEPTH];
  logic [1:0]  ref_ok  [DEPTH];

  vec_t vt[$];

  initial begin
    op_e         op;
    logic [17:0] a;
    logic        nlb, nub;
    logic [15:0] wd;
    op_e         p_op;
    logic [17:0] p_a;
    logic        p_nlb, p_nub;
    logic [15:0] p_wd;
    int unsigned m_rd, m_wr;
    logic        m_ec, m_er;
    logic        rd_vld;
    logic [15:0] rd_word;
    logic [1:0]  rd_ok;
    logic [15:0] io_now;
    logic [7:0]  exp_lane;
    logic        known, sel;
    int unsigned idx;

    nvec = 0;
    nmis = 0;

    // Reset with random non-write strobes: bus released, status cleared.
    i_reset_n = 1'b0;
    drive(OP_IDLE, '0, 1'b1, 1'b1, '0);
    for (int n = 0; n < 4; n++) begin
      op = ($urandom_range(0, 2) == 0) ? OP_IDLE : (($urandom_range(0, 1) == 1) ? OP_RD : OP_CT);
      drive(op, 18'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
      @(posedge i_clk);
      #1;
      check_state($sformatf("rst%0d", n), 16'hFFFF, 0, 0, 1'b0, 1'b0);
    end
    drive(OP_IDLE, '0, 1'b1, 1'b1, '0);
    #3;
    i_reset_n = 1'b1;
    step(OP_IDLE, '0, 1'b1, 1'b1, '0);

    // Directed table: one bus cycle per entry, outputs checked just after its sample edge.
    vt.push_back(mk(OP_WR,   18'h00005, 0, 0, 16'h1234, 16'h1234,  0, 0, 0, 0));
    vt.push_back(mk(OP_RD,   18'h00005, 0, 0, 16'h0000, 16'hFFFF,  0, 1, 0, 0));
    vt.push_back(mk(OP_RD,   18'h00005, 0, 0, 16'h0000, 16'h1234,  1, 1, 0, 0));
    vt.push_back(mk(OP_IDLE, 18'h00000, 1, 1, 16'h0000, 16'hFFFF,  2, 1, 0, 0));
    vt.push_back(mk(OP_WR,   18'h00007, 0, 0, 16'hAAAA, 16'hAAAA,  2, 1, 0, 0));
    vt.push_back(mk(OP_WR,   18'h00007, 0, 1, 16'h5566, 16'h5566,  2, 2, 0, 0));
    vt.push_back(mk(OP_RD,   18'h00007, 0, 0, 16'h0000, 16'hFFFF,  2, 3, 0, 0));
    vt.push_back(mk(OP_RD,   18'h00007, 0, 0, 16'h0000, 16'hAA66,  3, 3, 0, 0));
    vt.push_back(mk(OP_RD,   18'h00007, 1, 0, 16'h0000, 16'hAAFF,  4, 3, 0, 0));
    vt.push_back(mk(OP_IDLE, 18'h00000, 1, 1, 16'h0000, 16'hFFFF,  5, 3, 0, 0));
    vt.push_back(mk(OP_WR,   18'h00001, 0, 0, 16'hABCD, 16'hABCD,  5, 3, 0, 0));
    vt.push_back(mk(OP_WR,   18'h00002, 0, 0, 16'h9876, 16'h9876,  5, 4, 0, 0));
    vt.push_back(mk(OP_RD,   18'h00001, 0, 0, 16'h0000, 16'hFFFF,  5, 5, 0, 0));
    vt.push_back(mk(OP_RD,   18'h00002, 0, 0, 16'h0000, 16'hABCD,  6, 5, 0, 0));
    vt.push_back(mk(OP_RD,   18'h00002, 0, 0, 16'h0000, 16'h9876,  7, 5, 0, 0));
    vt.push_back(mk(OP_IDLE, 18'h00000, 1, 1, 16'h0000, 16'hFFFF,  8, 5, 0, 0));
    vt.push_back(mk(OP_CT,   18'h00001, 0, 0, 16'h0000, 16'hFFFF,  8, 5, 0, 0));
    vt.push_back(mk(OP_IDLE, 18'h00000, 1, 1, 16'h0000, 16'hFFFF,  8, 5, 1, 0));
    vt.push_back(mk(OP_RD,   18'h00001, 0, 0, 16'h0000, 16'hFFFF,  8, 5, 1, 0));
    vt.push_back(mk(OP_RD,   18'h00001, 0, 0, 16'h0000, 16'hABCD,  9, 5, 1, 0));
    vt.push_back(mk(OP_WR,   18'h00234, 0, 0, 16'h4321, 16'h4321, 10, 5, 1, 0));
    vt.push_back(mk(OP_RD,   18'h31234, 0, 0, 16'h0000, 16'hFFFF, 10, 6, 1, 0));
    vt.push_back(mk(OP_RD,   18'h31234, 0, 0, 16'h0000, 16'h4321, 11, 6, 1, 1));
    vt.push_back(mk(OP_IDLE, 18'h00000, 1, 1, 16'h0000, 16'hFFFF, 12, 6, 1, 1));

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].op, vt[i].addr, vt[i].nlb, vt[i].nub, vt[i].wd);
      check_state($sformatf("vec%0d", i), vt[i].exp_io, vt[i].exp_rd, vt[i].exp_wr,
                  vt[i].exp_ec, vt[i].exp_er);
      if (i == 14) begin
        // Master lifts nOE mid-cycle: both lanes must float before the next edge.
        bus.i_nOE = 1'b1;
        #1;
        check("noe_release_io", io_data, 16'hFFFF);
      end
    end

    // Read counter saturates at all-ones.
    for (int n = 0; n < 20; n++) step(OP_RD, 18'h00001, 1'b0, 1'b0, '0);
    check("sat_rd", o_rd_count, CNT_MAX);
    check("sat_io", io_data, 16'hABCD);
    step(OP_IDLE, '0, 1'b1, 1'b1, '0);
    check("sat_rd_hold", o_rd_count, CNT_MAX);
    check("sat_wr", o_wr_count, 6);

    // Reset asserted while read data is on the bus.
    step(OP_RD, 18'h00005, 1'b0, 1'b0, '0);
    step(OP_RD, 18'h00005, 1'b0, 1'b0, '0);
    check("pre_rst_io", io_data, 16'h1234);
    #2;
    i_reset_n = 1'b0;
    #1;
    check_state("midrst", 16'hFFFF, 0, 0, 1'b0, 1'b0);
    @(posedge i_clk);
    #4;
    i_reset_n = 1'b1;
    @(posedge i_clk);
    #1;
    check("post_rst_io0", io_data, 16'hFFFF);
    @(posedge i_clk);
    #1;
    check("post_rst_io1", io_data, 16'h1234);

    // Write sampled just before reset must never reach the RAM.
    step(OP_WR, 18'h00005, 1'b0, 1'b0, 16'h0F0F);
    drive(OP_IDLE, '0, 1'b1, 1'b1, '0);
    #1;
    i_reset_n = 1'b0;
    #2;
    i_reset_n = 1'b1;
    step(OP_RD, 18'h00005, 1'b0, 1'b0, '0);
    step(OP_RD, 18'h00005, 1'b0, 1'b0, '0);
    check_state("drop_wr", 16'h1234, 1, 0, 1'b0, 1'b0);

    // Random traffic against the reference model.
    drive(OP_IDLE, '0, 1'b1, 1'b1, '0);
    #1;
    i_reset_n = 1'b0;
    #2;
    i_reset_n = 1'b1;
    for (int unsigned k = 0; k < DEPTH; k++) ref_ok[k] = 2'b00;
    p_op = OP_IDLE; p_a = '0; p_nlb = 1'b1; p_nub = 1'b1; p_wd = '0;
    m_rd = 0; m_wr = 0; m_ec = 1'b0; m_er = 1'b0;

    for (int n = 0; n < 400; n++) begin
      if (n < 8) begin
        op = OP_WR; a = 18'(n); nlb = 1'b0; nub = 1'b0;
      end else begin
        int unsigned r;
        r  = $urandom_range(0, 99);
        op = (r < 40) ? OP_RD : (r < 75) ? OP_WR : (r < 80) ? OP_CT : OP_IDLE;
        a  = 18'($urandom_range(0, 7));
        if ($urandom_range(0, 15) == 0) a = a + 18'($urandom_range(1, 255) * DEPTH);
        nlb = 1'($urandom);
        nub = 1'($urandom);
      end
      wd = 16'($urandom);
      step(op, a, nlb, nub, wd);

      // Retire the cycle sampled one edge earlier.
      rd_vld  = 1'b0;
      rd_word = '0;
      rd_ok   = 2'b00;
      idx     = int'(p_a) % DEPTH;
      case (p_op)
        OP_WR: begin
          if (!p_nlb) begin ref_mem[idx][7:0]  = p_wd[7:0];  ref_ok[idx][0] = 1'b1; end
          if (!p_nub) begin ref_mem[idx][15:8] = p_wd[15:8]; ref_ok[idx][1] = 1'b1; end
          m_wr = sat_inc(m_wr);
          if (p_a >= DEPTH) m_er = 1'b1;
        end
        OP_RD: begin
          rd_vld  = 1'b1;
          rd_word = ref_mem[idx];
          rd_ok   = ref_ok[idx];
          m_rd    = sat_inc(m_rd);
          if (p_a >= DEPTH) m_er = 1'b1;
        end
        OP_CT:   m_ec = 1'b1;
        default: ;
      endcase

      io_now = io_data;
      for (int lane = 0; lane < 2; lane++) begin
        sel = (lane == 0) ? !nlb : !nub;
        if (op == OP_WR) begin
          exp_lane = wd[8*lane +: 8];
          known    = 1'b1;
        end else if (op == OP_RD && rd_vld && sel) begin
          exp_lane = rd_word[8*lane +: 8];
          known    = rd_ok[lane];
        end else begin
          exp_lane = 8'hFF;
          known    = 1'b1;
        end
        if (known) check($sformatf("rnd%0d_lane%0d", n, lane), io_now[8*lane +: 8], exp_lane);
      end
      check($sformatf("rnd%0d_rd", n), o_rd_count, m_rd);
      check($sformatf("rnd%0d_wr", n), o_wr_count, m_wr);
      check($sformatf("rnd%0d_ec", n), o_err_contention, m_ec);
      check($sformatf("rnd%0d_er", n), o_err_range, m_er);

      p_op = op; p_a = a; p_nlb = nlb; p_nub = nub; p_wd = wd;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
